// File: rtl/udp_tx_stream_arbiter_if.sv
// AXI-Stream bundle with LANES parallel valid/ready/last lanes sharing one tid.
// The arbiter takes NUM_PORTS lanes on its request side and drives one lane on its output side.
interface udp_tx_stream_arbiter_if #(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 2
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*KEEP_WIDTH-1:0] tkeep;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tlast;
  logic [LANES-1:0]            tready;
  logic [ID_WIDTH-1:0]         tid;

  modport master (output tdata, output tkeep, output tvalid, output tlast, output tid, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/udp_tx_stream_arbiter.sv
// Packet-locked round-robin mux of NUM_PORTS streams onto one stream; 1-cycle grant, 1-cycle data latency.
// A registered 2-entry skid buffer absorbs output stalls; the granted port's ready drops once both entries are full.
module udp_tx_stream_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                   tx_axis_aclk,
  input  logic                   tx_axis_aresetn,
  input  logic [NUM_PORTS-1:0]   port_enable,
  udp_tx_stream_arbiter_if.slave  s_axis,
  udp_tx_stream_arbiter_if.master m_axis,
  output logic                   busy,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic [31:0]            pkt_count
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]     r_rr_ptr, r_grant_id, w_grant_nxt, w_pick, w_idx;
  logic                    w_found;
  int                      v_idx;
  logic [NUM_PORTS-1:0]    w_req, r_tready, w_tready_nxt;
  logic [1:0]              r_cnt, w_cnt_nxt;
  logic                    w_push, w_pop, w_in_last;
  logic [DATA_WIDTH-1:0]   w_in_data, r_m_data, r_sk_data;
  logic [KEEP_WIDTH-1:0]   w_in_keep, r_m_keep, r_sk_keep;
  logic                    r_m_last, r_sk_last, r_m_valid, r_busy;
  logic [ID_WIDTH-1:0]     r_m_tid, r_sk_tid;
  logic [31:0]             r_pkt_count;

  assign w_req     = s_axis.tvalid & port_enable;
  assign w_in_data = s_axis.tdata[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign w_in_keep = s_axis.tkeep[int'(r_grant_id)*KEEP_WIDTH +: KEEP_WIDTH];
  assign w_in_last = s_axis.tlast[r_grant_id];
  // r_tready is only ever set for the granted port, so any handshake is a grant-port beat
  assign w_push    = |(s_axis.tvalid & r_tready);
  assign w_pop     = r_m_valid & m_axis.tready[0];

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    v_idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NUM_PORTS) v_idx = v_idx - NUM_PORTS;
      w_idx = ID_WIDTH'(v_idx);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    case (r_state)
      IDLE: if (w_found) begin
        w_state_nxt = BUSY;
        w_grant_nxt = w_pick;
      end
      BUSY: if (w_push && w_in_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_cnt_nxt    = r_cnt + 2'(w_push) - 2'(w_pop);
    // Ready is registered, so it is computed from next-cycle occupancy
    w_tready_nxt = '0;
    if (w_state_nxt == BUSY && w_cnt_nxt != 2'd2) w_tready_nxt[w_grant_nxt] = 1'b1;
  end

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_tready    <= '0;
      r_cnt       <= 2'd0;
      r_m_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_m_data    <= '0;
      r_m_keep    <= '0;
      r_m_last    <= 1'b0;
      r_m_tid     <= '0;
      r_sk_data   <= '0;
      r_sk_keep   <= '0;
      r_sk_last   <= 1'b0;
      r_sk_tid    <= '0;
      r_pkt_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_tready   <= w_tready_nxt;
      r_cnt      <= w_cnt_nxt;
      r_m_valid  <= (w_cnt_nxt != 2'd0);
      r_busy     <= (w_state_nxt == BUSY) || (w_cnt_nxt != 2'd0);
      if (w_push && w_in_last)
        r_rr_ptr <= (r_grant_id == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : r_grant_id + 1'b1;
      // Entry 0 is the output register itself; entry 1 only fills while the output stalls
      case (r_cnt)
        2'd0: if (w_push) begin
          r_m_data <= w_in_data;
          r_m_keep <= w_in_keep;
          r_m_last <= w_in_last;
          r_m_tid  <= r_grant_id;
        end
        2'd1: if (w_push && w_pop) begin
          r_m_data <= w_in_data;
          r_m_keep <= w_in_keep;
          r_m_last <= w_in_last;
          r_m_tid  <= r_grant_id;
        end else if (w_push) begin
          r_sk_data <= w_in_data;
          r_sk_keep <= w_in_keep;
          r_sk_last <= w_in_last;
          r_sk_tid  <= r_grant_id;
        end
        2'd2: if (w_pop) begin
          r_m_data <= r_sk_data;
          r_m_keep <= r_sk_keep;
          r_m_last <= r_sk_last;
          r_m_tid  <= r_sk_tid;
        end
        default: ;
      endcase
      if (w_pop && r_m_last) r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign s_axis.tready = r_tready;
  assign m_axis.tdata  = r_m_data;
  assign m_axis.tkeep  = r_m_keep;
  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tlast  = r_m_last;
  assign m_axis.tid    = r_m_tid;
  assign busy          = r_busy;
  assign grant_id      = r_grant_id;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_udp_tx_stream_arbiter.sv
// Directed bench for udp_tx_stream_arbiter: per-port packet sources, output/acceptance logs,
// and hand-derived expectations for ordering, timing, backpressure, masking, reset and counter wrap.
`define CHK(NM, OBS, EXP) \
  begin \
    tests++; \
    assert ((OBS) === (EXP)) else begin \
      fails++; \
      $error("FAIL %s: observed %0h expected %0h", NM, (OBS), (EXP)); \
    end \
  end

module tb_udp_tx_stream_arbiter;
  localparam int NP = 4;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int IW = 2;
  localparam logic [KW-1:0] KEEP_LAST = {32'h0, 32'hFFFF_FFFF};

  typedef struct { logic [IW-1:0] tid; logic [31:0] tag; logic last; logic [KW-1:0] keep; int cyc; } beat_t;
  typedef struct { logic [31:0] tag; int cyc; } acc_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NP-1:0]  port_enable;
  logic           busy;
  logic [IW-1:0]  grant_id;
  logic [31:0]    pkt_count;

  int tests = 0, fails = 0;
  int cyc = 0, onehot_err = 0, stab_err = 0, rep_err = 0;
  int src_len[NP]  = '{default: 1};
  int src_npkt[NP] = '{default: 0};
  int src_beat[NP] = '{default: 0};
  int src_pkt[NP]  = '{default: 0};
  int exp_ord[4];
  beat_t out_q[$];
  acc_t  acc_q[$];
  int    vld_cyc = 0;
  bit    vld_seen = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;
  logic [IW-1:0] prev_tid;

  udp_tx_stream_arbiter_if #(.LANES(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)) s_if ();
  udp_tx_stream_arbiter_if #(.LANES(1),  .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)) m_if ();

  udp_tx_stream_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)) dut (
    .tx_axis_aclk    (clk),
    .tx_axis_aresetn (rst_n),
    .port_enable     (port_enable),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .busy            (busy),
    .grant_id        (grant_id),
    .pkt_count       (pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag_of(int p, int k, int b);
    return {4'hA, 4'(p), 8'(k), 16'(b)};
  endfunction

  task automatic drive_src();
    for (int i = 0; i < NP; i++) begin
      logic lst;
      lst = (src_beat[i] == src_len[i] - 1);
      s_if.tvalid[i] = (src_npkt[i] > 0);
      s_if.tlast[i]  = lst;
      s_if.tdata[i*DW +: DW] = {16{tag_of(i, src_pkt[i], src_beat[i])}};
      s_if.tkeep[i*KW +: KW] = lst ? KEEP_LAST : {KW{1'b1}};
    end
  endtask

  task automatic load(int p, int len, int n);
    src_len[p] = len; src_npkt[p] = n; src_beat[p] = 0; src_pkt[p] = 0;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NP; i++) begin
      src_npkt[i] = 0; src_beat[i] = 0; src_pkt[i] = 0;
    end
  endtask

  task automatic clear_logs();
    out_q.delete(); acc_q.delete(); vld_seen = 1'b0;
  endtask

  task automatic wait_out(int n, int budget, string nm);
    for (int k = 0; k < budget && out_q.size() < n; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    `CHK(nm, out_q.size(), n)
  endtask

  task automatic wait_acc(int n, int budget, string nm);
    for (int k = 0; k < budget && acc_q.size() < n; k++) @(negedge clk);
    `CHK(nm, acc_q.size() >= n, 1'b1)
  endtask

  // Source driver and monitors: sample at the rising edge, redrive 1 time unit later
  initial begin
    drive_src();
    forever begin
      @(posedge clk);
      cyc++;
      if ($countones(s_if.tready) > 1) onehot_err++;
      if (prev_stall && (m_if.tdata !== prev_data || m_if.tkeep !== prev_keep ||
                         m_if.tlast[0] !== prev_last || m_if.tid !== prev_tid || m_if.tvalid[0] !== 1'b1))
        stab_err++;
      prev_stall = m_if.tvalid[0] & ~m_if.tready[0];
      prev_data = m_if.tdata; prev_keep = m_if.tkeep; prev_last = m_if.tlast[0]; prev_tid = m_if.tid;
      if (m_if.tvalid[0] && m_if.tready[0]) begin
        if (m_if.tdata !== {16{m_if.tdata[31:0]}}) rep_err++;
        out_q.push_back('{tid: m_if.tid, tag: m_if.tdata[31:0], last: m_if.tlast[0], keep: m_if.tkeep, cyc: cyc});
      end
      if (!vld_seen && |(s_if.tvalid & port_enable)) begin
        vld_seen = 1'b1; vld_cyc = cyc;
      end
      for (int i = 0; i < NP; i++) begin
        if (s_if.tvalid[i] && s_if.tready[i]) begin
          acc_q.push_back('{tag: s_if.tdata[i*DW +: 32], cyc: cyc});
          if (s_if.tlast[i]) begin
            src_beat[i] = 0; src_pkt[i]++; src_npkt[i]--;
          end else src_beat[i]++;
        end
      end
      #1;
      drive_src();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_if.tready = 1'b1;
    port_enable = '1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    `CHK("rst_mvalid", m_if.tvalid[0], 1'b0)
    `CHK("rst_sready", s_if.tready, 4'b0000)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_grant", grant_id, 2'd0)
    `CHK("rst_pktcnt", pkt_count, 32'd0)
    `CHK("rst_mdata", m_if.tdata, {DW{1'b0}})
    `CHK("rst_mkeep", m_if.tkeep, {KW{1'b0}})
    `CHK("rst_mlast", m_if.tlast[0], 1'b0)
    `CHK("rst_mtid", m_if.tid, 2'd0)
    rst_n = 1'b1;
    @(negedge clk);

    // Single port, 3 beats
    clear_logs();
    load(2, 3, 1);
    wait_out(3, 40, "t1_count");
    `CHK("t1_grant_lat", acc_q[0].cyc, vld_cyc + 1)
    for (int j = 0; j < 3; j++) begin
      `CHK("t1_tid", out_q[j].tid, 2'd2)
      `CHK("t1_tag", out_q[j].tag, tag_of(2, 0, j))
      `CHK("t1_last", out_q[j].last, (j == 2))
      `CHK("t1_keep", out_q[j].keep, ((j == 2) ? KEEP_LAST : {KW{1'b1}}))
      `CHK("t1_io_lat", out_q[j].cyc, acc_q[j].cyc + 1)
      `CHK("t1_b2b", out_q[j].cyc, out_q[0].cyc + j)
    end
    `CHK("t1_pktcnt", pkt_count, 32'd1)
    `CHK("t1_grant", grant_id, 2'd2)
    `CHK("t1_busy", busy, 1'b0)

    // All ports, 2 packets of 2 beats each, after a reset so the pointer starts at 0
    rst_n = 1'b0;
    @(negedge clk);
    `CHK("t2_rst_pktcnt", pkt_count, 32'd0)
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    for (int p = 0; p < NP; p++) load(p, 2, 2);
    wait_out(16, 120, "t2_count");
    `CHK("t2_grant_lat", acc_q[0].cyc, vld_cyc + 1)
    for (int j = 0; j < 8; j++) begin
      for (int b = 0; b < 2; b++) begin
        `CHK("t2_tid", out_q[2*j+b].tid, IW'(j % 4))
        `CHK("t2_tag", out_q[2*j+b].tag, tag_of(j % 4, j / 4, b))
        `CHK("t2_last", out_q[2*j+b].last, (b == 1))
      end
      `CHK("t2_inpkt_b2b", acc_q[2*j+1].cyc, acc_q[2*j].cyc + 1)
      if (j > 0) `CHK("t2_gap", acc_q[2*j].cyc, acc_q[2*j-1].cyc + 2)
    end
    `CHK("t2_pktcnt", pkt_count, 32'd8)

    // Output stall of 5 cycles inside a 6-beat packet from port 1
    clear_logs();
    load(1, 6, 1);
    for (int k = 0; k < 40 && out_q.size() < 2; k++) @(negedge clk);
    `CHK("t3_pre", out_q.size(), 2)
    m_if.tready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      `CHK("t3_occ", (acc_q.size() - out_q.size()) <= 2, 1'b1)
    end
    `CHK("t3_sready", s_if.tready, 4'b0000)
    `CHK("t3_held", acc_q.size() - out_q.size(), 2)
    `CHK("t3_mvalid", m_if.tvalid[0], 1'b1)
    `CHK("t3_head", m_if.tdata[31:0], tag_of(1, 0, 2))
    m_if.tready = 1'b1;
    wait_out(6, 40, "t3_count");
    for (int j = 0; j < 6; j++) begin
      `CHK("t3_tid", out_q[j].tid, 2'd1)
      `CHK("t3_tag", out_q[j].tag, tag_of(1, 0, j))
      `CHK("t3_last", out_q[j].last, (j == 5))
    end
    `CHK("t3_pktcnt", pkt_count, 32'd9)

    // Mask 1010: pointer is 2 after port 1, so ports 3,1,3,1; then unmask: 2,0,2,0
    clear_logs();
    port_enable = 4'b1010;
    for (int p = 0; p < NP; p++) load(p, 1, 2);
    wait_out(4, 60, "t4a_count");
    exp_ord = '{3, 1, 3, 1};
    for (int j = 0; j < 4; j++) begin
      `CHK("t4a_tid", out_q[j].tid, IW'(exp_ord[j]))
      `CHK("t4a_tag", out_q[j].tag, tag_of(exp_ord[j], j / 2, 0))
    end
    `CHK("t4a_busy", busy, 1'b0)
    port_enable = 4'b1111;
    wait_out(8, 60, "t4a_unmask_count");
    exp_ord = '{2, 0, 2, 0};
    for (int j = 0; j < 4; j++) begin
      `CHK("t4a_unmask_tid", out_q[4+j].tid, IW'(exp_ord[j]))
      `CHK("t4a_unmask_tag", out_q[4+j].tag, tag_of(exp_ord[j], j / 2, 0))
    end
    `CHK("t4a_pktcnt", pkt_count, 32'd17)

    // Disable port 1 after its first beat: packet must still complete
    clear_logs();
    load(1, 4, 1);
    wait_acc(1, 20, "t4b_start");
    port_enable = 4'b1101;
    wait_out(4, 40, "t4b_count");
    for (int j = 0; j < 4; j++) begin
      `CHK("t4b_tid", out_q[j].tid, 2'd1)
      `CHK("t4b_tag", out_q[j].tag, tag_of(1, 0, j))
      `CHK("t4b_last", out_q[j].last, (j == 3))
    end
    `CHK("t4b_pktcnt", pkt_count, 32'd18)
    port_enable = 4'b1111;

    // Reset on beat 2 of 4, then ports 0 and 3 compete: port 0 must win first
    clear_logs();
    load(3, 4, 1);
    wait_acc(2, 20, "t5_start");
    rst_n = 1'b0;
    clear_src();
    @(negedge clk);
    `CHK("t5_mvalid", m_if.tvalid[0], 1'b0)
    `CHK("t5_pktcnt", pkt_count, 32'd0)
    `CHK("t5_busy", busy, 1'b0)
    `CHK("t5_sready", s_if.tready, 4'b0000)
    `CHK("t5_grant", grant_id, 2'd0)
    clear_logs();
    load(0, 1, 1);
    load(3, 1, 1);
    repeat (2) @(negedge clk);
    `CHK("t5_quiet", out_q.size(), 0)
    rst_n = 1'b1;
    wait_out(2, 20, "t5_count");
    `CHK("t5_first_tid", out_q[0].tid, 2'd0)
    `CHK("t5_first_tag", out_q[0].tag, tag_of(0, 0, 0))
    `CHK("t5_second_tid", out_q[1].tid, 2'd3)
    `CHK("t5_second_tag", out_q[1].tag, tag_of(3, 0, 0))
    `CHK("t5_pktcnt", pkt_count, 32'd2)

    // Packet counter wraps from all-ones to zero
    force dut.r_pkt_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_pkt_count;
    @(negedge clk);
    `CHK("t6_preload", pkt_count, 32'hFFFF_FFFF)
    clear_logs();
    load(2, 2, 1);
    wait_out(2, 20, "t6_count");
    `CHK("t6_wrap", pkt_count, 32'd0)
    `CHK("t6_tag", out_q[1].tag, tag_of(2, 0, 1))

    `CHK("onehot_ready", onehot_err, 0)
    `CHK("out_stable", stab_err, 0)
    `CHK("data_integrity", rep_err, 0)

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udp_tx_stream_arbiter.md
# udp_tx_stream_arbiter

Packet-granular round-robin arbiter that shares the single UDP engine TX stream (`udp_tx_axis_*`) among NUM_PORTS user requesters. Each requester presents a 512-bit AXI-Stream. The arbiter locks onto one requester from grant until that requester's `tlast` beat, so packets are never interleaved. Output passes through a registered 2-entry skid buffer, giving full throughput inside a packet. A per-port enable mask, driven from the control register file, gates which requesters may win arbitration.

## Interface

Parameters:

- `NUM_PORTS`, 4 — number of requesters (2..16)
- `DATA_WIDTH`, 512 — stream data width
- `KEEP_WIDTH`, DATA_WIDTH/8 — byte-enable width
- `ID_WIDTH`, $clog2(NUM_PORTS) — width of the source-port tag

Ports:

- `tx_axis_aclk` in 1 — the block's only clock
- `tx_axis_aresetn` in 1 — reset, asynchronous assert, active-low
- `port_enable` in NUM_PORTS — per-port arbitration enable; bit i=1 lets port i be granted
- `s_axis_tdata` in NUM_PORTS*DATA_WIDTH — requester data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- `s_axis_tkeep` in NUM_PORTS*KEEP_WIDTH — requester byte enables
- `s_axis_tvalid` in NUM_PORTS — requester valid
- `s_axis_tlast` in NUM_PORTS — requester end of packet
- `s_axis_tready` out NUM_PORTS — per-requester ready; at most one bit is high in any cycle
- `m_axis_tdata` out DATA_WIDTH — data to `udp_tx_axis_tdata`
- `m_axis_tkeep` out KEEP_WIDTH — byte enables
- `m_axis_tvalid` out 1 — output valid
- `m_axis_tlast` out 1 — output end of packet
- `m_axis_tid` out ID_WIDTH — index of the port that sourced the beat
- `m_axis_tready` in 1 — from `udp_tx_axis_tready`
- `busy` out 1 — high while a grant is held
- `grant_id` out ID_WIDTH — currently or most recently granted port
- `pkt_count` out 32 — total packets forwarded; counts output `tlast` handshakes; wraps modulo 2^32

## Operation

FSM states:

- IDLE:
  - all `s_axis_tready` are 0.
  - Request vector = `s_axis_tvalid & port_enable`.
  - If non-zero, choose the first set bit searching upward from `rr_ptr`, wrapping from NUM_PORTS-1 to 0.
  - Register that index into `grant_id` and go to BUSY.
  - If the vector is zero, stay in IDLE.
- BUSY:
  - `s_axis_tready[grant_id]` = skid buffer not full (registered signal); all other ready bits are 0.
  - An accepted beat is written into the skid buffer, tagged with `grant_id`.
  - On acceptance of a beat with `tlast`=1: `rr_ptr` <= `grant_id`+1 (mod NUM_PORTS) and go to IDLE.

Enable and reset rules:

- `port_enable` is sampled only in IDLE.
- Clearing a port's enable bit during BUSY does not truncate its packet; the packet completes.
- Skid buffer: 2 entries; pop on `m_axis_tvalid & m_axis_tready`. Push and pop in the same cycle leave occupancy unchanged.
- `pkt_count` increments on each output handshake with `m_axis_tlast`=1.
- Reset values:
  - FSM = IDLE, `rr_ptr` = 0, `grant_id` = 0, `busy` = 0, `pkt_count` = 0.
  - `m_axis_tvalid` = 0, `s_axis_tready` = 0, skid buffer empty.
  - `m_axis_tdata`/`m_axis_tkeep`/`m_axis_tlast`/`m_axis_tid` = 0.
- Reset asserted mid-packet discards the partial packet and the buffered beats. After release the block re-arbitrates from port 0.

## Timing

- Grant latency: 1 cycle. The request is seen in IDLE, and the first beat can be accepted in the following cycle (BUSY).
- Per-packet overhead: exactly 1 idle input cycle between packets (the IDLE arbitration cycle).
- Input-to-output latency: 1 cycle. A beat accepted at edge N is presented with `m_axis_tvalid`=1 after edge N.
- Throughput:
  - 1 beat/cycle inside a packet while `m_axis_tready`=1.
  - While `m_axis_tready`=0, the buffer absorbs up to 2 beats, then `s_axis_tready` drops.
- All outputs are driven from registers; there are no combinational paths from input to output.
- AXI-Stream rules on the output:
  - `m_axis_*` stay stable while `m_axis_tvalid` & !`m_axis_tready`.
  - `m_axis_tvalid` never deasserts without a handshake.
- `busy` = (FSM==BUSY) | buffer non-empty.

## Test plan

1. Single port: port 2 sends a 3-beat packet with a stalled-free sink -> IDLE 1 cycle, then 3 output beats on consecutive cycles, `m_axis_tid`=2, `pkt_count`=1.
2. All 4 ports valid continuously with 2-beat packets -> grant order 0,1,2,3,0. No interleaving within a packet. Exactly one idle input cycle between packets.
3. Backpressure: `m_axis_tready` held low for 5 cycles mid-packet -> at most 2 beats buffered, `s_axis_tready` low after that, data order preserved, no beat lost or duplicated.
4. Enable masking:
   - `port_enable`=4'b1010 with all ports valid -> only ports 1 and 3 are granted, alternating.
   - Clearing bit 1 mid-packet from port 1 -> that packet completes in full.
5. Reset mid-packet: assert `tx_axis_aresetn` low on beat 2 of 4 -> `m_axis_tvalid`=0, `pkt_count`=0. After release, port 0 wins if it is valid.
6. `pkt_count` wrap: preload via forcing to 0xFFFF_FFFF, send 1 packet -> `pkt_count`=0.
